// File: rtl/data_memory_lsu.sv
// Data memory load/store unit: IDLE -> ACCESS -> RESP, single request in flight, ready_o only in IDLE, load result 2 cycles after acceptance.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned H/HU/W raise err_o instead of silently ignoring low offset bits.
module data_memory_lsu #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 1024,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  err_o
);

  localparam int AW   = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam int IDXW = DATA_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [0:MEMORY_DEPTH-1];

  logic [1:0]            w_off;
  logic [IDXW-1:0]       w_word_idx;
  logic [AW-1:0]         w_mem_idx;
  logic                  w_oor;
  logic                  w_size_bad;
  logic                  w_misalign;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_store_word;
  logic                  w_mem_we;

  // FSM outputs are decoded from state so reset clears them on the same edge.
  always_comb begin
    w_next   = r_state;
    ready_o  = 1'b0;
    rvalid_o = 1'b0;
    err_o    = 1'b0;
    rdata_o  = '0;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        if (req_i) w_next = ACCESS;
      end
      ACCESS: w_next = RESP;
      RESP: begin
        rvalid_o = 1'b1;
        err_o    = r_err;
        rdata_o  = r_rdata;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && req_i) begin
      r_we     <= we_i;
      r_funct3 <= funct3_i;
      r_addr   <= addr_i;
      r_wdata  <= wdata_i;
    end
  end

  // Address decode and error classification on the captured request.
  always_comb begin
    w_off      = r_addr[1:0];
    w_word_idx = r_addr[DATA_WIDTH-1:2] - BASE_ADDR[DATA_WIDTH-1:2];
    w_mem_idx  = w_word_idx[AW-1:0];
    w_oor      = (r_addr < BASE_ADDR) || (w_word_idx >= IDXW'(MEMORY_DEPTH));
    w_size_bad = (r_funct3[1:0] == 2'b11) || (r_funct3[2] && r_funct3[1]);
`ifdef DMEM_MISALIGN_TRAP_EN
    w_misalign = ((r_funct3[1:0] == 2'b01) && w_off[0]) ||
                 ((r_funct3[1:0] == 2'b10) && (w_off != 2'b00));
`else
    w_misalign = 1'b0;
`endif
    w_err      = w_oor || w_size_bad || w_misalign;
  end

  // Halfword lane uses only offset[1]; offset[0] is either trapped or ignored.
  always_comb begin
    w_word = r_mem[w_mem_idx];
    w_byte = w_word[{w_off, 3'b000} +: 8];
    w_half = w_off[1] ? w_word[31:16] : w_word[15:0];
    case (r_funct3)
      3'b000:  w_load = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_load = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_load = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_load = '0;
    endcase
  end

  always_comb begin
    w_store_word = w_word;
    case (r_funct3[1:0])
      2'b00:   w_store_word[{w_off, 3'b000} +: 8]      = r_wdata[7:0];
      2'b01:   w_store_word[{w_off[1], 4'b0000} +: 16] = r_wdata[15:0];
      2'b10:   w_store_word = r_wdata;
      default: w_store_word = w_word;
    endcase
    w_mem_we = (r_state == ACCESS) && r_we && !w_err && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else if (r_state == ACCESS) begin
      r_err   <= w_err;
      r_rdata <= (w_err || r_we) ? '0 : w_load;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_store_word;
  end

endmodule

// File: doc/data_memory_lsu.md
DATA_MEMORY_LSU -- requirements
Module: data_memory_lsu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data and address width in bits.
REQ-002 SHALL have parameter MEMORY_DEPTH, default 1024, number of DATA_WIDTH-bit words.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h1001_0000, byte address of word 0.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_i  input  1  access request, qualified by ready_o.
REQ-007 SHALL have port we_i  input  1  1 = store, 0 = load.
REQ-008 SHALL have port funct3_i  input  3  RISC-V size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port addr_i  input  DATA_WIDTH  byte address.
REQ-010 SHALL have port wdata_i  input  DATA_WIDTH  store data, right-aligned.
REQ-011 SHALL have port ready_o  output  1  block can accept a request this cycle.
REQ-012 SHALL have port rdata_o  output  DATA_WIDTH  load result, valid while rvalid_o is high.
REQ-013 SHALL have port rvalid_o  output  1  one-cycle completion pulse for loads and stores.
REQ-014 SHALL have port err_o  output  1  completion carries an error; meaningful only while rvalid_o is high.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, ACCESS, RESP.
REQ-016 SHALL assert ready_o only in IDLE; a request is accepted when req_i and ready_o are both high at a rising edge.
REQ-017 SHALL ignore req_i in ACCESS and RESP; accepted requests SHALL NOT be queued.
REQ-018 On acceptance, SHALL register we_i, funct3_i, addr_i and wdata_i and move IDLE -> ACCESS.
REQ-019 SHALL compute word index = (addr - BASE_ADDR) >> 2 and byte offset = addr[1:0].
REQ-020 SHALL flag out-of-range when addr < BASE_ADDR or word index >= MEMORY_DEPTH.
REQ-021 SHALL flag an illegal size for funct3 values 011, 110 and 111.
REQ-022 In ACCESS, an error-free store SHALL write only the addressed byte lanes: B to lane offset, H to lanes offset and offset+1, W to all four lanes, using wdata_i[7:0] / [15:0] / [31:0].
REQ-023 In ACCESS, a load SHALL register the addressed word; ACCESS -> RESP always.
REQ-024 In RESP, SHALL drive rvalid_o = 1 for exactly one cycle and then return to IDLE; load-to-rvalid latency is 2 cycles after acceptance.
REQ-025 A load result SHALL be the selected byte or halfword shifted to bit 0, sign-extended for B/H and zero-extended for BU/HU; W SHALL return the full word.
REQ-026 Store completions SHALL drive rdata_o = 0.
REQ-027 On any error, SHALL leave memory unmodified, drive err_o = 1 and rdata_o = 0.
REQ-028 A load issued after a completed store to the same address SHALL return the newly written data.
REQ-029 Outside RESP, SHALL hold rvalid_o = 0, err_o = 0 and rdata_o = 0.

Reset
REQ-030 reset SHALL force the FSM to IDLE and drive ready_o = 1, rvalid_o = 0, err_o = 0 and rdata_o = 0 on the next edge.
REQ-031 reset asserted in ACCESS SHALL cancel the write and produce no completion; reset SHALL take priority over a simultaneous req_i.
REQ-032 reset SHALL NOT clear memory contents.

Configuration
REQ-033 With DMEM_MISALIGN_TRAP_EN defined, SHALL raise an error for H/HU with offset[0] = 1 and for W with offset != 0.
REQ-034 Without DMEM_MISALIGN_TRAP_EN, misalignment SHALL NOT cause an error: H/HU SHALL ignore offset[0] and W SHALL ignore offset[1:0]; all other rules are unchanged.

Verification
REQ-035 Store W 0xDEADBEEF at 0x1001_0000, then load W at the same address -> rvalid_o 2 cycles after acceptance, rdata_o = 0xDEADBEEF, err_o = 0.
REQ-036 Load B at 0x1001_0003 and BU at 0x1001_0003 after REQ-035 -> 0xFFFFFFDE and 0x000000DE.
REQ-037 Store H 0x1234 at 0x1001_0002, then load W at 0x1001_0000 -> 0x1234BEEF.
REQ-038 Load W at 0x1001_1000 (index 1024) -> rvalid_o with err_o = 1 and rdata_o = 0; memory is unchanged.
REQ-039 Load H at 0x1001_0001 -> err_o = 1 with the macro defined; without it, rdata_o = 0xFFFFBEEF and err_o = 0.
REQ-040 Assert reset during ACCESS of a store W 0x0 to 0x1001_0000 -> no rvalid_o; a later load at that address returns the prior value.
